// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, branch-mode encodings and ID/EX bubble constant
package decode_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int CTRL_W_DEF = 10;
  typedef enum logic [2:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_RSVD
  } br_mode_e;
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } ex_flags_t;
  localparam ex_flags_t EX_BUBBLE = '0;
endpackage

// File: rtl/reg_bank_p.sv
// reg_bank_p: register bank with async clear, r0 hardwired to zero and write-through bypass
// Ports: clk/rst_n; we_i/waddr_i/wdata_i write port; raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o
module reg_bank_p #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);
  logic [XLEN-1:0] regs_q [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (we_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
  assign rdata_a_o = raddr_a_i == '0 ? '0 : (we_i && waddr_i == raddr_a_i) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = raddr_b_i == '0 ? '0 : (we_i && waddr_i == raddr_b_i) ? wdata_i : regs_q[raddr_b_i];
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: MIPS ID stage with branch resolution, hazard detection and ID/EX register
// Ports: IF/ID inputs (if_*), ControlUnit inputs (ctrl_*, br_mode, imm_zext), flush,
// WB write port (wb_*), MEM-stage flags (mem_*); outputs stall, br_taken/br_target, ID/EX (ex_*)
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_inst,
  input  logic [XLEN-1:0]   if_pc4,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              ctrl_regwrite,
  input  logic              ctrl_memread,
  input  logic              ctrl_regdst,
  input  logic [2:0]        br_mode,
  input  logic              imm_zext,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [AW-1:0]     mem_rd,
  input  logic [XLEN-1:0]   mem_alu,
  output logic              stall,
  output logic              br_taken,
  output logic [XLEN-1:0]   br_target,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc4,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_dest
);
  logic [AW-1:0] rs, rt, rd;
  logic [XLEN-1:0] bank_a, bank_b, op_a, op_b, imm;
  logic mem_fwd, ex_hz, mem_hz, hz_rs, hz_rt, lu, bh, cond, bubble, unused_opcode;
  br_mode_e mode;
  ex_flags_t flags_d, flags_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [XLEN-1:0] a_d, a_q, b_d, b_q, imm_d, imm_q, pc4_d, pc4_q;
  logic [AW-1:0] rs_d, rs_q, rt_d, rt_q, dest_d, dest_q;
  assign unused_opcode = ^if_inst[31:26];
  assign rs = AW'(if_inst[25:21]);
  assign rt = AW'(if_inst[20:16]);
  assign rd = AW'(if_inst[15:11]);
  assign imm = imm_zext ? {{(XLEN-16){1'b0}}, if_inst[15:0]} : {{(XLEN-16){if_inst[15]}}, if_inst[15:0]};
  assign br_target = if_pc4 + (imm << 2);
  assign mode = br_mode_e'(br_mode);
  reg_bank_p #(.XLEN(XLEN), .NREG(NREG)) u_bank (
    .clk(clk), .rst_n(rst_n), .we_i(wb_we), .waddr_i(wb_addr), .wdata_i(wb_data),
    .raddr_a_i(rs), .raddr_b_i(rt), .rdata_a_o(bank_a), .rdata_b_o(bank_b)
  );
  // Only a finished ALU result in MEM can be forwarded; a load there is still in flight.
  assign mem_fwd = mem_regwrite & ~mem_memread & (mem_rd != '0);
  assign op_a = (mem_fwd && mem_rd == rs) ? mem_alu : bank_a;
  assign op_b = (mem_fwd && mem_rd == rt) ? mem_alu : bank_b;
  assign lu = ex_valid & ex_memread & (ex_dest != '0) & ((ex_dest == rs) | (ex_dest == rt));
  assign ex_hz = ex_valid & ex_regwrite & (ex_dest != '0);
  assign mem_hz = mem_regwrite & mem_memread & (mem_rd != '0);
  assign hz_rs = (ex_hz & (ex_dest == rs)) | (mem_hz & (mem_rd == rs));
  assign hz_rt = (ex_hz & (ex_dest == rt)) | (mem_hz & (mem_rd == rt));
  assign bh = (mode != BR_NONE) & (hz_rs | ((mode == BR_BEQ || mode == BR_BNE) & hz_rt));
  always_comb begin
    cond = 1'b0;
    case (mode)
      BR_BEQ:  cond = op_a == op_b;
      BR_BNE:  cond = op_a != op_b;
      BR_BLEZ: cond = op_a[XLEN-1] | (op_a == '0);
      BR_BGTZ: cond = ~op_a[XLEN-1] & (op_a != '0);
      BR_BLTZ: cond = op_a[XLEN-1];
      BR_BGEZ: cond = ~op_a[XLEN-1];
      default: cond = 1'b0;
    endcase
  end
  assign stall = if_valid & (lu | bh) & ~flush;
  assign br_taken = if_valid & ~stall & ~flush & cond;
  assign bubble = flush | stall | ~if_valid;
  assign flags_d = bubble ? EX_BUBBLE : {1'b1, ctrl_regwrite, ctrl_memread};
  assign ctrl_d = bubble ? '0 : ctrl_in;
  assign a_d = bubble ? '0 : bank_a;
  assign b_d = bubble ? '0 : bank_b;
  assign imm_d = bubble ? '0 : imm;
  assign pc4_d = bubble ? '0 : if_pc4;
  assign rs_d = bubble ? '0 : rs;
  assign rt_d = bubble ? '0 : rt;
  assign dest_d = bubble ? '0 : (ctrl_regdst ? rd : rt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flags_q <= EX_BUBBLE;
      ctrl_q <= '0;
      a_q <= '0;
      b_q <= '0;
      imm_q <= '0;
      pc4_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      dest_q <= '0;
    end else begin
      flags_q <= flags_d;
      ctrl_q <= ctrl_d;
      a_q <= a_d;
      b_q <= b_d;
      imm_q <= imm_d;
      pc4_q <= pc4_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      dest_q <= dest_d;
    end
  assign ex_valid = flags_q.valid;
  assign ex_regwrite = flags_q.regwrite;
  assign ex_memread = flags_q.memread;
  assign ex_ctrl = ctrl_q;
  assign ex_a = a_q;
  assign ex_b = b_q;
  assign ex_imm = imm_q;
  assign ex_pc4 = pc4_q;
  assign ex_rs = rs_q;
  assign ex_rt = rt_q;
  assign ex_dest = dest_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed stimulus with a reference model compared every cycle
module tb_decode_stage_p;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid, ctrl_regwrite, ctrl_memread, ctrl_regdst, imm_zext, flush, wb_we, mem_regwrite, mem_memread;
  logic [31:0] if_inst, if_pc4, wb_data, mem_alu;
  logic [9:0] ctrl_in;
  logic [2:0] br_mode;
  logic [4:0] wb_addr, mem_rd;
  logic stall, br_taken, ex_valid, ex_regwrite, ex_memread;
  logic [31:0] br_target, ex_a, ex_b, ex_imm, ex_pc4;
  logic [9:0] ex_ctrl;
  logic [4:0] ex_rs, ex_rt, ex_dest;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  decode_stage_p dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
    .ctrl_in(ctrl_in), .ctrl_regwrite(ctrl_regwrite), .ctrl_memread(ctrl_memread),
    .ctrl_regdst(ctrl_regdst), .br_mode(br_mode), .imm_zext(imm_zext), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_rd(mem_rd), .mem_alu(mem_alu), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // reference model: architectural register file plus the expected ID/EX contents
  logic [31:0] mreg [32];
  logic m_valid, m_rw, m_mr;
  logic [9:0] m_ctrl;
  logic [31:0] m_a, m_b, m_imm, m_pc4;
  logic [4:0] m_rs, m_rt, m_dest;
  function automatic logic [4:0] f_rs(); return if_inst[25:21]; endfunction
  function automatic logic [4:0] f_rt(); return if_inst[20:16]; endfunction
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_we && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction
  function automatic logic [31:0] moper(input logic [4:0] a);
    if (mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == a) return mem_alu;
    return mread(a);
  endfunction
  function automatic logic busy(input logic [4:0] r);
    return r != 0 && ((m_valid && m_rw && m_dest == r) || (mem_regwrite && mem_memread && mem_rd == r));
  endfunction
  function automatic logic mstall();
    logic lu, bh;
    lu = m_valid && m_mr && m_dest != 0 && (m_dest == f_rs() || m_dest == f_rt());
    bh = br_mode != 0 && (busy(f_rs()) || ((br_mode == 1 || br_mode == 2) && busy(f_rt())));
    return if_valid && (lu || bh) && !flush;
  endfunction
  function automatic logic mtaken();
    int signed a, b;
    logic c;
    a = moper(f_rs());
    b = moper(f_rt());
    case (br_mode)
      3'd1: c = a == b;
      3'd2: c = a != b;
      3'd3: c = a <= 0;
      3'd4: c = a > 0;
      3'd5: c = a < 0;
      3'd6: c = a >= 0;
      default: c = 0;
    endcase
    return if_valid && !mstall() && !flush && c;
  endfunction
  function automatic logic [31:0] mimm();
    return imm_zext ? {16'h0, if_inst[15:0]} : {{16{if_inst[15]}}, if_inst[15:0]};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mreg[i] = 0;
      {m_valid, m_rw, m_mr, m_ctrl, m_a, m_b, m_imm, m_pc4, m_rs, m_rt, m_dest} = '0;
    end else begin
      logic live;
      live = if_valid && !flush && !mstall();
      m_valid = live;
      m_rw = live && ctrl_regwrite;
      m_mr = live && ctrl_memread;
      m_ctrl = live ? ctrl_in : 0;
      m_a = live ? mread(f_rs()) : 0;
      m_b = live ? mread(f_rt()) : 0;
      m_imm = live ? mimm() : 0;
      m_pc4 = live ? if_pc4 : 0;
      m_rs = live ? f_rs() : 0;
      m_rt = live ? f_rt() : 0;
      m_dest = live ? (ctrl_regdst ? if_inst[15:11] : f_rt()) : 0;
      if (wb_we && wb_addr != 0) mreg[wb_addr] = wb_data;
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("m_stall", stall, mstall());
    chk("m_br_taken", br_taken, mtaken());
    chk("m_br_target", br_target, if_pc4 + (mimm() << 2));
    chk("m_ex_valid", ex_valid, m_valid);
    chk("m_ex_regwrite", ex_regwrite, m_rw);
    chk("m_ex_memread", ex_memread, m_mr);
    chk("m_ex_ctrl", ex_ctrl, m_ctrl);
    chk("m_ex_a", ex_a, m_a);
    chk("m_ex_b", ex_b, m_b);
    chk("m_ex_imm", ex_imm, m_imm);
    chk("m_ex_pc4", ex_pc4, m_pc4);
    chk("m_ex_rs", ex_rs, m_rs);
    chk("m_ex_rt", ex_rt, m_rt);
    chk("m_ex_dest", ex_dest, m_dest);
  end
  function automatic logic [31:0] ity(input logic [4:0] s, t, input logic [15:0] im);
    return {6'd4, s, t, im};
  endfunction
  function automatic logic [31:0] rty(input logic [4:0] s, t, d);
    return {6'd0, s, t, d, 11'd0};
  endfunction
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle();
    {if_valid, ctrl_regwrite, ctrl_memread, ctrl_regdst, imm_zext, flush, wb_we, mem_regwrite, mem_memread} = '0;
    {if_inst, if_pc4, wb_data, mem_alu, ctrl_in, br_mode, wb_addr, mem_rd} = '0;
  endtask
  task automatic issue(input logic [31:0] inst, input logic [2:0] mode, input logic rw, mr, rdst, input logic [31:0] pc4);
    if_valid = 1; if_inst = inst; br_mode = mode; ctrl_regwrite = rw; ctrl_memread = mr;
    ctrl_regdst = rdst; if_pc4 = pc4; ctrl_in = inst[9:0] ^ 10'h2A5; imm_zext = 0; flush = 0;
  endtask
  task automatic wb(input logic [4:0] a, input logic [31:0] d); wb_we = 1; wb_addr = a; wb_data = d; endtask
  initial begin
    logic [7:0] tk_tab;
    tk_tab = 8'h52;
    idle();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ex_valid", ex_valid, 0); chk("rst_ex_a", ex_a, 0); chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_stall", stall, 0); chk("rst_br_taken", br_taken, 0);
    tick(); rst_n = 1; wb(5, 32'h5555);
    tick(); wb_we = 0; issue(rty(5, 0, 6), 0, 1, 0, 1, 32'h10);
    tick(); @(negedge clk);
    chk("add_ex_a", ex_a, 32'h5555); chk("add_ex_dest", ex_dest, 6);
    chk("add_ex_valid", ex_valid, 1); chk("add_ex_ctrl", ex_ctrl, 10'h2A5);
    #2 rst_n = 0; #1;
    chk("midrst_ex_valid", ex_valid, 0); chk("midrst_ex_a", ex_a, 0); chk("midrst_ex_dest", ex_dest, 0);
    idle(); tick(); rst_n = 1; issue(rty(5, 0, 6), 0, 1, 0, 1, 32'h10);
    tick(); @(negedge clk);
    chk("r5_after_rst", ex_a, 0); chk("r5_ex_valid", ex_valid, 1);
    tick(); issue(ity(3, 0, 16'h0001), 1, 0, 0, 0, 32'h80); wb(3, 32'h1234);
    @(negedge clk); chk("byp_beq_taken", br_taken, 0);
    tick(); issue(ity(4, 0, 16'h0008), 2, 0, 0, 0, 32'h200); wb(4, 32'h1234);
    @(negedge clk);
    chk("byp_ex_a", ex_a, 32'h1234); chk("byp_bne_taken", br_taken, 1); chk("byp_bne_target", br_target, 32'h220);
    tick(); wb_we = 0; issue(ity(1, 2, 16'h0000), 0, 1, 1, 0, 32'h300);
    tick(); issue(rty(2, 1, 4), 0, 1, 0, 1, 32'h304);
    @(negedge clk); chk("lu_stall", stall, 1);
    tick(); @(negedge clk); chk("lu_bubble", ex_valid, 0); chk("lu_stall_clear", stall, 0);
    tick(); idle(); wb(8, 5);
    @(negedge clk); chk("lu_issue_valid", ex_valid, 1); chk("lu_issue_dest", ex_dest, 4);
    tick(); wb_we = 0; mem_rd = 7; mem_alu = 32'hFFFF_FFFF; mem_regwrite = 1;
    issue(ity(7, 0, 16'hFFFC), 5, 0, 0, 0, 32'h100);
    @(negedge clk);
    chk("fwd_bltz_taken", br_taken, 1); chk("fwd_bltz_target", br_target, 32'hF0); chk("fwd_stall", stall, 0);
    for (int m = 1; m < 8; m++) begin
      tick(); mem_regwrite = 0; mem_rd = 0; issue(ity(8, 8, 16'h0004), 3'(m), 0, 0, 0, 32'h40);
      @(negedge clk); chk("mode_taken", br_taken, tk_tab[m]);
    end
    tick(); issue(ity(0, 0, 16'hFFFC), 0, 0, 0, 0, 32'h50); imm_zext = 1;
    tick(); @(negedge clk); chk("zext_imm", ex_imm, 32'h0000_FFFC);
    tick(); issue(ity(1, 2, 16'h0000), 0, 1, 1, 0, 32'h400);
    tick(); issue(ity(2, 2, 16'h0000), 1, 0, 0, 0, 32'h404); flush = 1;
    @(negedge clk); chk("flush_stall", stall, 0); chk("flush_taken", br_taken, 0);
    tick(); idle(); @(negedge clk); chk("flush_bubble", ex_valid, 0);
    tick(); issue(ity(1, 9, 16'h0000), 0, 1, 1, 0, 32'h500);
    tick(); issue(ity(9, 9, 16'h0010), 1, 0, 0, 0, 32'h300);
    @(negedge clk); chk("bl_stall1", stall, 1); chk("bl_taken1", br_taken, 0);
    tick(); mem_rd = 9; mem_regwrite = 1; mem_memread = 1;
    @(negedge clk); chk("bl_stall2", stall, 1);
    tick(); mem_rd = 0; mem_regwrite = 0; mem_memread = 0; wb(9, 32'h77);
    @(negedge clk);
    chk("bl_stall3", stall, 0); chk("bl_taken", br_taken, 1); chk("bl_target", br_target, 32'h340);
    tick(); idle();
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage_p.md
# decode_stage_p

Parametrised instruction-decode stage for the pipelined MIPS core, sitting between the IF/ID and EX stages. It reads the register bank and computes operand forwarding internally, with no external forwarding selects. It resolves all MIPS conditional branch modes in ID, detects load-use and branch-operand hazards, and owns the ID/EX pipeline register with stall and flush control.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; AW = $clog2(NREG); register 0 reads as zero
- CTRL_W, 10, opaque control bundle carried to EX from the ControlUnit

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  IF/ID holds a real instruction
- if_inst  in  32  instruction word
- if_pc4  in  XLEN  PC+4 of the instruction
- ctrl_in  in  CTRL_W  decoded control bundle, passed through
- ctrl_regwrite, ctrl_memread, ctrl_regdst  in  1 each  decoded write, load and dest-select flags
- br_mode  in  3  branch mode: 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved
- imm_zext  in  1  zero-extend immediate (otherwise sign-extend)
- flush  in  1  kill the ID instruction
- wb_we  in  1  writeback enable
- wb_addr  in  AW  writeback register
- wb_data  in  XLEN  writeback data
- mem_regwrite, mem_memread  in  1 each  MEM-stage flags
- mem_rd  in  AW  MEM-stage destination register
- mem_alu  in  XLEN  MEM-stage ALU result
- stall  out  1  hold PC and IF/ID this cycle
- br_taken  out  1  redirect fetch to br_target
- br_target  out  XLEN  if_pc4 + (imm << 2), modulo 2^XLEN
- ex_valid, ex_regwrite, ex_memread  out  1 each  registered
- ex_ctrl  out  CTRL_W  registered
- ex_a, ex_b, ex_imm, ex_pc4  out  XLEN  registered
- ex_rs, ex_rt, ex_dest  out  AW  registered; ex_dest = regdst ? rd : rt

## Operation
- Register bank: write on the rising edge when wb_we is set and wb_addr != 0. Reads are combinational, with a same-cycle bypass: when wb_we is set and wb_addr equals the read address (nonzero), the read returns wb_data. Register 0 always reads 0.
- Branch operands A (rs) and B (rt), highest priority first:
  1. mem_alu, when mem_regwrite, !mem_memread, mem_rd != 0 and mem_rd matches.
  2. Bank read (which includes the wb bypass).
- Conditions, in signed XLEN arithmetic: BEQ A==B; BNE A!=B; BLEZ A<=0; BGTZ A>0; BLTZ A<0; BGEZ A>=0. Mode 7 never takes.
- Load-use hazard (lu): ex_valid & ex_memread & ex_dest != 0 & (ex_dest == rs | ex_dest == rt). Compare both rs and rt conservatively.
- Branch hazard (bh): br_mode != 0, and the operands the mode needs (rs always; rt for BEQ/BNE) match a nonzero destination that is either:
  - ex_dest, with ex_valid & ex_regwrite, or
  - mem_rd, with mem_regwrite & mem_memread.
- stall = if_valid & (lu | bh) & !flush.
- br_taken = if_valid & !stall & !flush & condition.
- ID/EX update, rising edge:
  - flush or stall or !if_valid: load a bubble. ex_valid, ex_regwrite and ex_memread go to 0, ex_ctrl to 0, and data fields to 0.
  - Otherwise: load the decoded fields, ex_valid = 1, and ex_a/ex_b = bank reads. EX-stage forwarding handles the rest.
- flush has priority over stall.

## Timing
- Reset (rst_n low, asynchronous): all ex_* outputs are 0 and all registers in the bank are 0. stall and br_taken are combinational and therefore 0 while if_valid = 0.
- ID/EX latency: 1 cycle.
- stall, br_taken and br_target are valid in the same cycle as the inputs.
- A write in cycle N is visible to a read in cycle N through the bypass, and to the bank in N+1.
- A load followed immediately by a dependent instruction: stall for 1 cycle.
- A branch depending on the immediately preceding ALU op: stall 1 cycle, then take mem_alu forwarding.
- A branch depending on a load: stall 2 cycles.
- When rst_n is deasserted mid-stream, operation restarts from the reset state. No partial state survives.

## Structure
- Package decode_pkg holds the br_mode encodings as a typedef enum (BR_NONE … BR_BGEZ), the default widths, and the ID/EX bubble constant.
- Sub-module reg_bank_p (parameters XLEN, NREG) contains the bank, the asynchronous reset and the wb bypass.
- decode_stage_p contains forwarding, hazard, compare, extend/target and the ID/EX register.

## Test plan
- Reset: assert rst_n=0 mid-run. All ex_* outputs read 0 immediately, and reading r5 after release returns 0.
- Bypass: wb_we=1, wb_addr=3, wb_data=0x1234, with BEQ r3,r0 in ID the same cycle. Required: br_taken=0, and ex_a=0x1234 the next cycle. BNE r3,r0 gives br_taken=1.
- Load-use: lw r2 in EX (ex_memread=1, ex_dest=2), add r4,r2,r1 in ID. Required: stall=1 for one cycle, ex_valid=0 in the next cycle, then the add issues.
- Branch forwarding: mem_rd=7, mem_alu=0xFFFFFFFF, mem_regwrite=1. BLTZ r7 with if_pc4=0x100 and imm=-4. Required: br_taken=1, br_target=0xF0.
- Flush with a hazard: assert flush together with a load-use condition. Required: stall=0, br_taken=0, ex_valid=0 the next cycle.
- Branch on load: a load into r9 in EX, then BEQ r9,r9 in ID. Required: stall for 2 cycles, then br_taken=1.
